// File: rtl/pmem_types.sv
// rtl/pmem_types.sv - shared types and widths for the pmem line-bus responder
package pmem_types;

    localparam int PMEM_LINE_W   = 256;
    localparam int PMEM_OFFSET_W = 5;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - line-wide backing store, one sync read port and one sync write port
module pmem_line_array
    import pmem_types::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic                rd_en,
    output pmem_line_t          rd_line,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_en,
    input  pmem_line_t          wr_line
);

    pmem_line_t mem [2**IDX_BITS];

    // Write port: commit a full line when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
    end

    // Read port: registered line out, holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_line <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency pmem target; optional protocol checker under PMEM_CHECK_EN
module pmem_responder
    import pmem_types::*;
#(
    parameter int LATENCY  = 10,
    parameter int IDX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  pmem_line_t  pmem_wdata,
    output logic        pmem_resp,
    output pmem_line_t  pmem_rdata,
    output logic        proto_err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    pmem_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                cap_write_q;
    logic [IDX_BITS-1:0] cap_idx_q;
    pmem_line_t          cap_wdata_q;
    logic                rdata_vld_q;
    pmem_line_t          arr_line;

    logic                req;
    logic [IDX_BITS-1:0] req_idx;
    logic                capture;
    logic                commit;
    logic                rd_en;
    logic                unused_addr_bits;

    assign req     = pmem_read | pmem_write;
    assign req_idx = pmem_address[IDX_BITS+PMEM_OFFSET_W-1:PMEM_OFFSET_W];
    assign unused_addr_bits = ^{pmem_address[31:IDX_BITS+PMEM_OFFSET_W],
                                pmem_address[PMEM_OFFSET_W-1:0]};

    // Read-and-write together is a write, so the store is only read for a pure read.
    assign capture = (state_q == IDLE) && req;
    assign commit  = (state_q == WAIT) && (cnt_q == '0);
    assign rd_en   = capture && !pmem_write;

    // Response decodes purely from state registers; no input reaches it.
    assign pmem_resp = commit;

    // The array output register has no reset, so a valid flag masks it to 0 until the first read.
    assign pmem_rdata = rdata_vld_q ? arr_line : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE waits for a request, WAIT returns once the count has run out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)    state_d = WAIT;
            WAIT:    if (commit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latency counter and request capture; inputs are ignored while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_wdata_q <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            if (capture) begin
                cnt_q       <= CNT_LOAD;
                cap_write_q <= pmem_write;
                cap_idx_q   <= req_idx;
                cap_wdata_q <= pmem_wdata;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (rd_en) begin
                rdata_vld_q <= 1'b1;
            end
        end
    end

    pmem_line_array #(
        .IDX_BITS (IDX_BITS)
    ) u_line_array (
        .clk     (clk),
        .rd_idx  (req_idx),
        .rd_en   (rd_en),
        .rd_line (arr_line),
        .wr_idx  (cap_idx_q),
        .wr_en   (commit && cap_write_q),
        .wr_line (cap_wdata_q)
    );

`ifdef PMEM_CHECK_EN
    logic err_q;
    logic viol;

    // Violation detect: dual request at capture, or a request not held steady before the response.
    always_comb begin
        viol = 1'b0;
        if (state_q == IDLE) begin
            viol = pmem_read && pmem_write;
        end else if (cnt_q != '0) begin
            viol = !req
                || (pmem_write != cap_write_q)
                || (req_idx != cap_idx_q)
                || (cap_write_q && (pmem_wdata != cap_wdata_q));
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed vector bench for pmem_responder at LATENCY 10 and 1
module tb_pmem_responder;
    import pmem_types::*;

`ifdef PMEM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd10 = 1'b0, wr10 = 1'b0;
    logic [31:0] addr10 = '0;
    pmem_line_t  wd10 = '0;
    logic        resp10, err10;
    pmem_line_t  rdata10;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0;
    pmem_line_t  wd1 = '0;
    logic        resp1, err1;
    pmem_line_t  rdata1;

    int n_vec = 0;
    int n_err = 0;
    pmem_line_t exp_last;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(10), .IDX_BITS(8)) dut10 (
        .clk(clk), .rst(rst),
        .pmem_read(rd10), .pmem_write(wr10), .pmem_address(addr10), .pmem_wdata(wd10),
        .pmem_resp(resp10), .pmem_rdata(rdata10), .proto_err(err10)
    );

    pmem_responder #(.LATENCY(1), .IDX_BITS(8)) dut1 (
        .clk(clk), .rst(rst),
        .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1), .pmem_wdata(wd1),
        .pmem_resp(resp1), .pmem_rdata(rdata1), .proto_err(err1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        pmem_line_t  wdata;
        pmem_line_t  exp_rdata;
    } vec_t;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input pmem_line_t act, input pmem_line_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One transaction on the LATENCY=10 instance; called just after a negedge (cycle t).
    task automatic txn10(input string nm, input logic rd, input logic wr, input logic [31:0] addr,
                         input pmem_line_t wd, input pmem_line_t exp_rd);
        rd10 = rd; wr10 = wr; addr10 = addr; wd10 = wd;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk_bit({nm, " resp"}, resp10, (c == 10));
            if (c == 10) begin
                chk_line({nm, " rdata"}, rdata10, exp_rd);
                rd10 = 1'b0; wr10 = 1'b0;
            end
        end
        @(negedge clk);
        chk_bit({nm, " resp after"}, resp10, 1'b0);
    endtask

    vec_t vecs[7];
    pmem_line_t line_a5, line_x, line_l255, line_z, line_y, line_w, line_q;

    initial begin
        line_a5   = {32{8'hA5}};
        line_x    = {8{32'hDEAD_BEEF}};
        line_l255 = {16{16'h1234}};
        line_z    = {8{32'h0F0F_1E1E}};
        line_y    = {8{32'hCAFE_F00D}};
        line_w    = {4{64'h0123_4567_89AB_CDEF}};
        line_q    = {8{32'h5A5A_0001}};

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, line_a5,   '0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_005C, '0,        line_a5};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_2000, line_x,    '0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0000, '0,        line_x};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_1FE0, line_l255, '0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFE7, '0,        line_l255};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0044, '0,        line_a5};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_bit("reset resp10", resp10, 1'b0);
        chk_line("reset rdata10", rdata10, '0);
        chk_bit("reset err10", err10, 1'b0);
        chk_bit("reset resp1", resp1, 1'b0);
        rst = 1'b0;
        exp_last = '0;
        @(negedge clk);

        // Table: writes leave rdata at the last read value, reads return the stored line
        foreach (vecs[i]) begin
            pmem_line_t e;
            e = vecs[i].rd && !vecs[i].wr ? vecs[i].exp_rdata : exp_last;
            txn10($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e);
            exp_last = e;
        end
        chk_bit("no err after clean traffic", err10, 1'b0);

        // LATENCY=1: fill line 1, then hold a read for three cycles
        rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'h20; wd1 = line_q;
        @(negedge clk);
        chk_bit("lat1 wr resp", resp1, 1'b1);
        chk_line("lat1 wr rdata", rdata1, '0);
        wr1 = 1'b0;
        @(negedge clk);
        chk_bit("lat1 idle", resp1, 1'b0);
        rd1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk_bit($sformatf("lat1 b2b resp c%0d", c), resp1, (c != 2));
            if (c != 2) chk_line($sformatf("lat1 b2b rdata c%0d", c), rdata1, line_q);
        end
        rd1 = 1'b0;
        @(negedge clk);
        chk_bit("lat1 b2b done", resp1, 1'b0);

        // Reset in the middle of a write discards it
        txn10("wr Z", 1'b0, 1'b1, 32'h100, line_z, exp_last);
        rd10 = 1'b0; wr10 = 1'b1; addr10 = 32'h100; wd10 = line_y;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_bit($sformatf("wr Y resp c%0d", c), resp10, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk_bit("mid rst resp", resp10, 1'b0);
        chk_line("mid rst rdata", rdata10, '0);
        chk_bit("mid rst err", err10, 1'b0);
        exp_last = '0;
        wr10 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk_bit("post rst no resp", resp10, 1'b0);
        end
        txn10("rd after rst", 1'b1, 1'b0, 32'h100, '0, line_z);
        exp_last = line_z;

        // Read and write together: performed as a write, flagged when checking is built
        txn10("rd+wr", 1'b1, 1'b1, 32'h180, line_w, exp_last);
        chk_bit("rd+wr err", err10, CHK);
        txn10("rd 180", 1'b1, 1'b0, 32'h180, '0, line_w);
        exp_last = line_w;
        chk_bit("err sticky", err10, CHK);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bit("err cleared", err10, 1'b0);
        @(negedge clk);

        // Address index changes in WAIT: captured address still used
        rd10 = 1'b1; wr10 = 1'b0; addr10 = 32'h40;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) addr10 = 32'h60;
            chk_bit($sformatf("idx chg resp c%0d", c), resp10, (c == 10));
        end
        chk_line("idx chg rdata", rdata10, line_a5);
        rd10 = 1'b0;
        @(negedge clk);
        chk_bit("idx chg err", err10, CHK);
        chk_bit("idx chg idle", resp10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Synthesizable physical-memory responder for the cache's 256-bit line bus: the target end of the `pmem_*` protocol the cache drives as initiator. It holds a line-addressed backing store, accepts one read or write request at a time, and answers after a fixed, parameterized latency with a single-cycle `pmem_resp` pulse. It sits beside `cpu` and `cache` in the mp2 top level, standing in for main memory in simulation and in FPGA builds.

## Interface
- `LATENCY`, 10: cycles from request sample to response, ≥1.
- `IDX_BITS`, 8: line-index width; store holds 2^IDX_BITS lines of 32 bytes.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pmem_read` in 1: read request, held until response.
- `pmem_write` in 1: write request, held until response.
- `pmem_address` in 32: byte address; bits [4:0] ignored, line index = [IDX_BITS+4:5], upper bits ignored.
- `pmem_wdata` in 256: write line, held with `pmem_write`.
- `pmem_resp` out 1: one-cycle completion pulse.
- `pmem_rdata` out 256: read line, valid while `pmem_resp` high.
- `proto_err` out 1: sticky protocol-violation flag (see Configuration).

## Operation
- States: IDLE, WAIT.
- IDLE: at an edge with `pmem_read|pmem_write` high, capture op, index, `pmem_wdata`; load `cnt = LATENCY-1`; load `pmem_rdata` from store[index] (read only); go WAIT.
- Both read and write high: treated as write; `pmem_rdata` not loaded.
- WAIT: `pmem_resp = (cnt == 0)`. If `cnt != 0`, decrement. If `cnt == 0`: commit captured write to store at this edge, go IDLE.
- Inputs ignored in WAIT; captured values are used.
- Back-to-back: a request high in the IDLE cycle after a response is a new request. An initiator that does not drop its request after `pmem_resp` reissues it.
- `pmem_rdata` holds its last loaded value between responses. Write responses leave it unchanged.
- Store contents are not reset and are undefined at power-up. Reset does not touch the store.
- Reset at any time: state IDLE, `cnt` 0, `pmem_resp` 0, `pmem_rdata` 0, `proto_err` 0. A pending write is discarded.

## Timing
- Request first high in IDLE cycle t gives `pmem_resp` high in cycle t+LATENCY only. With LATENCY=1, the response is in cycle t+1.
- A write is visible to a read captured at or after cycle t+LATENCY+1.
- Minimum request-to-request spacing: LATENCY+1 cycles.
- `pmem_resp` and `pmem_rdata` are driven from registers only, with no combinational input-to-output path.

## Configuration
- `PMEM_CHECK_EN` defined: `proto_err` is set and held until reset when any of the following occurs:
  - read and write are both high at a capture edge;
  - in WAIT, the request drops before `pmem_resp`;
  - in WAIT, the op changes, or `pmem_address` index changes;
  - in WAIT, `pmem_wdata` changes during a write.
- `PMEM_CHECK_EN` undefined: `proto_err` is tied 0 and no checker logic is built. Functional behaviour is otherwise identical.

## Structure
- Package `pmem_types`:
  - `PMEM_LINE_W` = 256, `PMEM_OFFSET_W` = 5;
  - `pmem_line_t`;
  - `pmem_state_t` enum {IDLE, WAIT}.
- Sub-module `pmem_line_array`:
  - parameter IDX_BITS;
  - synchronous read port (index, read enable, registered line out);
  - synchronous write port (index, write enable, line in);
  - no reset.
- `pmem_responder` holds the FSM, counter, capture registers, and checker.

## Test plan
- Write then read, LATENCY=10: write 0x…A5 line to address 0x0000_0040. `pmem_resp` is high only in cycle t+10. Read of 0x0000_005C (same line) then returns the A5 line in cycle t'+10.
- LATENCY=1 back-to-back: hold `pmem_read` to address 0x20 for 3 cycles. Expect `pmem_resp` pulses in cycles t+1 and t+3, and `pmem_rdata` equal to store[1] both times.
- Aliasing, IDX_BITS=8:
  - write line X to 0x0000_2000, then read 0x0000_0000;
  - read returns X (index 0);
  - `pmem_rdata` is unchanged during the write response.
- Reset mid-write:
  - write line Y to address 0x100;
  - assert `rst` in cycle t+4;
  - expect outputs 0 immediately, no `pmem_resp`;
  - a later read of 0x100 returns the prior contents, not Y.
- Checker, `PMEM_CHECK_EN` defined: drive read and write together. Write is performed and `proto_err` rises the next cycle and stays high until `rst`. With `PMEM_CHECK_EN` undefined, `proto_err` stays 0.
- Checker, `PMEM_CHECK_EN` defined: change the address index in WAIT cycle t+2. The response uses the captured address and `proto_err` is set.
